// File: rtl/pll_lock_rst_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pll_lock_rst_ctrl
// Description : Bring-up controller for the PLL output clock domain.
//               - Synchronizes the PLL LOCK flag.
//               - Holds downstream logic in reset until lock has been stable
//                 for STABLE_CYCLES cycles.
//               - Generates a prescaled one-cycle tick while running.
//               - Keeps a sticky record of any lock loss seen while running.
// Config      : Define PLL_LOCK_LOSS_RESET_EN to make a lock loss in RUN
//               re-assert sys_rst_n and restart the bring-up sequence.
//               When it is undefined, RUN is left only through rst_n.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_lock_rst_ctrl #(
    parameter int STABLE_CYCLES = 1024,
    parameter int SYNC_STAGES   = 2,
    parameter int PRESCALE_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pll_lock,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  clr_lost,
    output logic                  sys_rst_n,
    output logic                  tick,
    output logic                  running,
    output logic                  lock_lost
);

    // Stable counter must be able to hold STABLE_CYCLES itself.
    localparam int c_cnt_w = $clog2(STABLE_CYCLES + 1);

    // Count value at which the final qualifying cycle is seen.
    localparam logic [c_cnt_w-1:0] c_stable_last = c_cnt_w'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RUN       = 2'd2
    } state_t;

    state_t                  state_q;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic [c_cnt_w-1:0]      stable_cnt_q;
    logic [PRESCALE_W-1:0]   div_cnt_q;
    logic                    sys_rst_n_q;
    logic                    tick_q;
    logic                    running_q;
    logic                    lock_lost_q;
    logic                    lock_lost_d;
    logic                    lock_s;
    logic                    lock_lost_set;
    logic                    div_wrap;

    // Only the last synchronizer stage is trusted by the FSM.
    assign lock_s = sync_q[SYNC_STAGES-1];

    // Lock loss is only meaningful once the domain has been released.
    assign lock_lost_set = (state_q == RUN) && !lock_s;

    // A '>=' compare lets a live decrease of prescale wrap immediately.
    assign div_wrap = (div_cnt_q >= prescale);

    // Sticky lock-lost flag: a new loss event wins over a clear request.
    always_comb begin
        lock_lost_d = lock_lost_q;
        if (lock_lost_set) begin
            lock_lost_d = 1'b1;
        end else if (clr_lost) begin
            lock_lost_d = 1'b0;
        end
    end

    // Multi-flop synchronizer for the asynchronous PLL lock flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
        end
    end

    // Bring-up FSM with stable counter, prescaler and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= WAIT_LOCK;
            stable_cnt_q <= '0;
            div_cnt_q    <= '0;
            sys_rst_n_q  <= 1'b0;
            tick_q       <= 1'b0;
            running_q    <= 1'b0;
            lock_lost_q  <= 1'b0;
        end else begin
            lock_lost_q <= lock_lost_d;

            case (state_q)
                WAIT_LOCK: begin
                    // Downstream held in reset; counters parked at zero.
                    stable_cnt_q <= '0;
                    div_cnt_q    <= '0;
                    sys_rst_n_q  <= 1'b0;
                    tick_q       <= 1'b0;
                    running_q    <= 1'b0;
                    if (lock_s) begin
                        state_q <= STABLE;
                    end
                end

                STABLE: begin
                    tick_q <= 1'b0;
                    if (!lock_s) begin
                        // A glitch restarts qualification; not a lock loss.
                        state_q      <= WAIT_LOCK;
                        stable_cnt_q <= '0;
                    end else if (stable_cnt_q == c_stable_last) begin
                        // Release reset on the same edge RUN is entered.
                        state_q      <= RUN;
                        stable_cnt_q <= '0;
                        div_cnt_q    <= '0;
                        sys_rst_n_q  <= 1'b1;
                        running_q    <= 1'b1;
                    end else begin
                        stable_cnt_q <= stable_cnt_q + c_cnt_w'(1);
                    end
                end

                RUN: begin
`ifdef PLL_LOCK_LOSS_RESET_EN
                    if (!lock_s) begin
                        // Lock gone: pull the domain back into reset.
                        state_q      <= WAIT_LOCK;
                        stable_cnt_q <= '0;
                        div_cnt_q    <= '0;
                        sys_rst_n_q  <= 1'b0;
                        running_q    <= 1'b0;
                        tick_q       <= 1'b0;
                    end else begin
                        sys_rst_n_q <= 1'b1;
                        running_q   <= 1'b1;
                        if (div_wrap) begin
                            tick_q    <= 1'b1;
                            div_cnt_q <= '0;
                        end else begin
                            tick_q    <= 1'b0;
                            div_cnt_q <= div_cnt_q + PRESCALE_W'(1);
                        end
                    end
`else
                    // Lock loss is only recorded; the domain keeps running.
                    sys_rst_n_q <= 1'b1;
                    running_q   <= 1'b1;
                    if (div_wrap) begin
                        tick_q    <= 1'b1;
                        div_cnt_q <= '0;
                    end else begin
                        tick_q    <= 1'b0;
                        div_cnt_q <= div_cnt_q + PRESCALE_W'(1);
                    end
`endif
                end

                default: begin
                    // Unreachable encoding: recover into a held-reset state.
                    state_q      <= WAIT_LOCK;
                    stable_cnt_q <= '0;
                    div_cnt_q    <= '0;
                    sys_rst_n_q  <= 1'b0;
                    tick_q       <= 1'b0;
                    running_q    <= 1'b0;
                end
            endcase
        end
    end

    assign sys_rst_n = sys_rst_n_q;
    assign tick      = tick_q;
    assign running   = running_q;
    assign lock_lost = lock_lost_q;

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_rst_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_lock_rst_ctrl
// Description : Scoreboard bench for pll_lock_rst_ctrl with SYNC_STAGES=2,
//               STABLE_CYCLES=4. Expected outputs are queued against an
//               absolute clock-edge index and compared by a monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_lock_rst_ctrl;

    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pll_lock;
    logic [PW-1:0] prescale;
    logic          clr_lost;
    logic          sys_rst_n;
    logic          tick;
    logic          running;
    logic          lock_lost;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    typedef struct {
        string    name;
        int       cyc;
        logic [3:0] v;   // {sys_rst_n, tick, running, lock_lost}
    } exp_t;

    exp_t exp_q[$];

    pll_lock_rst_ctrl #(
        .STABLE_CYCLES (4),
        .SYNC_STAGES   (2),
        .PRESCALE_W    (PW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pll_lock  (pll_lock),
        .prescale  (prescale),
        .clr_lost  (clr_lost),
        .sys_rst_n (sys_rst_n),
        .tick      (tick),
        .running   (running),
        .lock_lost (lock_lost)
    );

    always #5 clk = ~clk;

    // Edge index: value seen at a negedge equals the number of posedges so far.
    always @(posedge clk) edge_n <= edge_n + 1;

    // Queue an expectation for a future edge index.
    task automatic expect_at(input string name, input int cyc, input logic [3:0] v);
        exp_t e;
        e.name = name;
        e.cyc  = cyc;
        e.v    = v;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: compare every expectation that is due at this edge index.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= edge_n) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (e.cyc < edge_n) begin
                errors++;
                $display("FAIL %s: expectation for edge %0d missed (now %0d)", e.name, e.cyc, edge_n);
            end else if ({sys_rst_n, tick, running, lock_lost} !== e.v) begin
                errors++;
                $display("FAIL %s @edge %0d: got {srst,tick,run,lost}=%b required %b",
                         e.name, edge_n, {sys_rst_n, tick, running, lock_lost}, e.v);
            end
        end
    end

    // Watchdog keeps the run bounded.
    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: run did not complete (pending %0d)", exp_q.size());
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : stim
        int k, c, c2, c3, c4, k2;
        rst_n    = 1'b0;
        pll_lock = 1'b0;
        prescale = 8'd3;
        clr_lost = 1'b0;
        step(3);

        // Reset state.
        checks++;
        if ({sys_rst_n, tick, running, lock_lost} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_state: got %b required 0000", {sys_rst_n, tick, running, lock_lost});
        end

        // Bring-up with lock already present; prescale = 3.
        rst_n    = 1'b1;
        pll_lock = 1'b1;
        k = edge_n;
        expect_at("bringup_e1",      k + 1,  4'b0000);
        expect_at("bringup_pre",     k + 6,  4'b0000);
        expect_at("bringup_release", k + 7,  4'b1010);
        expect_at("ps3_no_tick",     k + 10, 4'b1010);
        expect_at("ps3_first_tick",  k + 11, 4'b1110);
        expect_at("ps3_after_tick",  k + 12, 4'b1010);
        expect_at("ps3_second_tick", k + 15, 4'b1110);
        step(16);

        // prescale = 0: tick every cycle.
        c = edge_n;
        prescale = 8'd0;
        expect_at("ps0_tick_a", c + 1, 4'b1110);
        expect_at("ps0_tick_b", c + 2, 4'b1110);
        expect_at("ps0_tick_c", c + 3, 4'b1110);
        step(3);

        // prescale = 9, then lowered to 2 while div_cnt = 6.
        c2 = edge_n;
        prescale = 8'd9;
        expect_at("ps9_count_1", c2 + 1, 4'b1010);
        expect_at("ps9_count_6", c2 + 6, 4'b1010);
        step(6);
        prescale = 8'd2;
        expect_at("lower_wrap_tick", c2 + 7,  4'b1110);
        expect_at("lower_gap_a",     c2 + 8,  4'b1010);
        expect_at("lower_gap_b",     c2 + 9,  4'b1010);
        expect_at("ps2_tick",        c2 + 10, 4'b1110);
        expect_at("ps2_gap",         c2 + 11, 4'b1010);
        expect_at("ps2_tick_next",   c2 + 13, 4'b1110);
        step(8);

        // Lock loss in RUN.
        c3 = edge_n;
        pll_lock = 1'b0;
        expect_at("loss_pre",  c3 + 2, 4'b1110);
`ifdef PLL_LOCK_LOSS_RESET_EN
        expect_at("loss_set",  c3 + 3, 4'b0001);
        expect_at("loss_held", c3 + 10, 4'b0001);
        expect_at("loss_rerelease", c3 + 11, 4'b1011);
`else
        expect_at("loss_set",  c3 + 3, 4'b1011);
        expect_at("loss_tick", c3 + 5, 4'b1111);
        expect_at("loss_tick_b", c3 + 11, 4'b1111);
`endif
        step(4);
        pll_lock = 1'b1;
        expect_at("loss_tick_c", c3 + 14, 4'b1111);
        step(11);

        // lock_lost: clear alone, then clear coinciding with a new loss.
        c4 = edge_n;
        clr_lost = 1'b1;
        pll_lock = 1'b0;
        expect_at("clr_alone",    c4 + 1, 4'b1010);
        expect_at("clr_tick",     c4 + 2, 4'b1110);
`ifdef PLL_LOCK_LOSS_RESET_EN
        expect_at("set_beats_clr", c4 + 3, 4'b0001);
        expect_at("clr_held",      c4 + 9, 4'b0001);
        expect_at("clr_rerelease", c4 + 10, 4'b1011);
`else
        expect_at("set_beats_clr", c4 + 3, 4'b1011);
        expect_at("clr_tick_b",    c4 + 8, 4'b1111);
`endif
        step(1);
        clr_lost = 1'b0;
        step(1);
        clr_lost = 1'b1;
        step(1);
        clr_lost = 1'b0;
        pll_lock = 1'b1;
        step(9);

        // Asynchronous reset mid-RUN: outputs drop without a clock edge.
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({sys_rst_n, tick, running, lock_lost} !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset: got %b required 0000", {sys_rst_n, tick, running, lock_lost});
        end
        step(1);

        // Re-bring-up with a 3-cycle lock glitch at STABLE count 2.
        rst_n = 1'b1;
        k2 = edge_n;
        expect_at("rb_stable",       k2 + 5,  4'b0000);
        expect_at("rb_glitch_back",  k2 + 6,  4'b0000);
        expect_at("rb_delayed",      k2 + 12, 4'b0000);
        expect_at("rb_release",      k2 + 13, 4'b1010);
        expect_at("rb_first_tick",   k2 + 16, 4'b1110);
        step(3);
        pll_lock = 1'b0;
        step(3);
        pll_lock = 1'b1;
        step(12);

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL pending: %0d expectations never compared", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
